alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised successor to the single-cycle coprocessor ALU.
- Keeps the ADD/SUB/MUL/DIV op_code interface and the Hi/Lo result convention.
- Returns full double-width products, uses a multi-cycle shift-add multiplier and a restoring divider so wide BITNESS closes timing, and adds busy, carry, divide-by-zero and illegal-op reporting.
- Sits between the command decoder and the result return path.

Parameters:
- BITNESS, 8, operand/result width in bits; must be >= 2.
- ADD, 8'b00000001, op_code for addition.
- SUB, 8'b00000010, op_code for subtraction.
- MUL, 8'b00000011, op_code for unsigned multiply.
- DIV, 8'b00000100, op_code for unsigned divide/modulo.

Ports:
- i_clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_ready  input  1  operation request strobe.
- i_num_1  input  BITNESS  operand A (dividend, minuend).
- i_num_2  input  BITNESS  operand B (divisor, subtrahend).
- op_code  input  8  operation select.
- o_busy  output  1  high while a MUL/DIV iteration is in progress.
- o_ready  output  1  one-cycle pulse when results and flags are valid.
- result_Hi  output  BITNESS  primary result.
- result_Lo  output  BITNESS  secondary result.
- o_carry  output  1  ADD carry-out / SUB borrow.
- o_div_zero  output  1  DIV with i_num_2 == 0.
- o_bad_op  output  1  unrecognised op_code.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; all outputs 0; iteration counter 0; latched operands 0. Takes effect immediately, including mid-MUL/DIV. The in-flight operation is discarded; no o_ready is produced for it.
- States:
  - IDLE: accepts requests.
  - RUN: BITNESS iterations of MUL or DIV.
  - No separate DONE state; results are written on the final RUN edge and the FSM returns to IDLE.
- Accept:
  - Occurs at a rising edge where i_ready=1 and state is IDLE (o_busy=0). That is "edge 1".
  - op_code, i_num_1 and i_num_2 are latched at edge 1; later input changes have no effect.
  - i_ready while o_busy=1 is ignored; it is not queued.
- Single-cycle ops (ADD, SUB, DIV-by-zero, illegal op):
  - Results, flags and the o_ready pulse appear after edge 1; latency 1.
  - o_busy stays 0.
- ADD: result_Hi = (A+B) mod 2^BITNESS; o_carry = bit BITNESS of the sum; result_Lo = 0.
- SUB: result_Hi = (A-B) mod 2^BITNESS; o_carry = 1 iff A < B; result_Lo = 0.
- MUL (unsigned):
  - Edge 1 enters RUN with counter 0; o_busy=1.
  - One shift-add iteration per edge on edges 2..BITNESS+1.
  - At edge BITNESS+1: {result_Hi,result_Lo} = A*B (full 2*BITNESS bits); o_ready pulses; o_busy=0; FSM returns to IDLE.
  - Latency BITNESS+1.
- DIV (unsigned, B != 0):
  - Restoring divide, one quotient bit per edge; same timing as MUL.
  - result_Hi = A / B; result_Lo = A % B.
- DIV with B == 0: result_Hi = all ones; result_Lo = A; o_div_zero=1; latency 1.
- Illegal op_code: result_Hi = result_Lo = 0; o_bad_op=1; latency 1.
- Flags:
  - Flags not relevant to an operation are written 0 when that operation completes.
  - Results and flags are written only on completion and hold until the next completion or reset.
  - Intermediate RUN values never appear on the outputs.
- o_ready is high for exactly one cycle per accepted request.
- Back-to-back: o_busy is already 0 in the o_ready cycle, so i_ready asserted in that cycle is accepted at the next edge.
- Consecutive ADDs with i_ready held high: one result per cycle, one o_ready pulse each.
- Counter width is clog2(BITNESS+1); the counter must not wrap before the final iteration for any legal BITNESS.

Test Plan:
- BITNESS=8, ADD 200+100 -> after edge 1: result_Hi=0x2C, o_carry=1, result_Lo=0, one-cycle o_ready. SUB 5-7 -> result_Hi=0xFE, o_carry=1.
- MUL 0xFF*0xFF -> o_busy high edges 1..8, o_ready after edge 9, result_Hi=0xFE, result_Lo=0x01; outputs unchanged during RUN.
- DIV 200/7 -> after edge 9: result_Hi=28, result_Lo=4, o_div_zero=0. DIV 37/0 -> after edge 1: result_Hi=0xFF, result_Lo=37, o_div_zero=1, o_busy never high.
- MUL 12*13 accepted, i_ready with ADD 1+1 pulsed at edge 4 -> ADD ignored, only the MUL o_ready (result 156: Hi=0x00, Lo=0x9C). Then ADD 1+1 issued in the o_ready cycle -> accepted, result_Hi=2 one cycle later.
- Reset low asynchronously at edge 5 of DIV 255/3 -> outputs 0 immediately, no o_ready after release. Fresh DIV 255/3 -> Hi=85, Lo=0.
- op_code 0x09 -> after edge 1: o_bad_op=1, results 0. Following valid ADD clears o_bad_op. Repeat the MUL/DIV checks with BITNESS=16 (0xFFFF*0xFFFF -> Hi=0xFFFE, Lo=0x0001, o_ready after edge 17).

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq: operands and op_code in, results, flags and handshake out.
// The master side issues requests; the slave side is the ALU.
interface alu_seq_if #(
    parameter int BITNESS = 8
);
    logic               i_ready;
    logic [BITNESS-1:0] i_num_1;
    logic [BITNESS-1:0] i_num_2;
    logic [7:0]         op_code;
    logic               o_busy;
    logic               o_ready;
    logic [BITNESS-1:0] result_Hi;
    logic [BITNESS-1:0] result_Lo;
    logic               o_carry;
    logic               o_div_zero;
    logic               o_bad_op;

    modport master (
        output i_ready, i_num_1, i_num_2, op_code,
        input  o_busy, o_ready, result_Hi, result_Lo, o_carry, o_div_zero, o_bad_op
    );

    modport slave (
        input  i_ready, i_num_1, i_num_2, op_code,
        output o_busy, o_ready, result_Hi, result_Lo, o_carry, o_div_zero, o_bad_op
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: ADD/SUB/DIV-by-0/illegal in 1 cycle, MUL/DIV in BITNESS+1 cycles (shift-add, restoring).
// Requests arriving while o_busy is high are dropped, not queued; o_ready pulses once per accepted request.
module alu_seq #(
    parameter int         BITNESS = 8,
    parameter logic [7:0] ADD     = 8'b00000001,
    parameter logic [7:0] SUB     = 8'b00000010,
    parameter logic [7:0] MUL     = 8'b00000011,
    parameter logic [7:0] DIV     = 8'b00000100
) (
    input  logic      i_clk,
    input  logic      reset,
    alu_seq_if.slave  io_bus
);
    localparam int              CW   = $clog2(BITNESS + 1);
    localparam logic [CW-1:0]   LAST = CW'(BITNESS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic                   r_is_div, w_is_div_nxt;
    logic [BITNESS-1:0]     r_b, w_b_nxt;
    logic [2*BITNESS-1:0]   r_p, w_p_nxt;
    logic [BITNESS-1:0]     r_hi, w_hi_nxt;
    logic [BITNESS-1:0]     r_lo, w_lo_nxt;
    logic                   r_ready, w_ready_nxt;
    logic                   r_carry, w_carry_nxt;
    logic                   r_dz, w_dz_nxt;
    logic                   r_bad, w_bad_nxt;

    logic [BITNESS:0]       w_add, w_sub, w_mul_sum, w_div_sh;
    logic [BITNESS-1:0]     w_div_rem;
    logic                   w_div_ge;
    logic [2*BITNESS-1:0]   w_mul_step, w_div_step, w_step;

    assign w_add = {1'b0, io_bus.i_num_1} + {1'b0, io_bus.i_num_2};
    assign w_sub = {1'b0, io_bus.i_num_1} - {1'b0, io_bus.i_num_2};

    // r_p holds {partial product, remaining multiplier} for MUL and {remainder, dividend/quotient} for DIV
    assign w_mul_sum  = {1'b0, r_p[2*BITNESS-1:BITNESS]} + {1'b0, {BITNESS{r_p[0]}} & r_b};
    assign w_mul_step = {w_mul_sum, r_p[BITNESS-1:1]};

    assign w_div_sh   = {r_p[2*BITNESS-1:BITNESS], r_p[BITNESS-1]};
    assign w_div_ge   = (w_div_sh >= {1'b0, r_b});
    assign w_div_rem  = w_div_sh[BITNESS-1:0] - r_b;
    assign w_div_step = w_div_ge ? {w_div_rem, r_p[BITNESS-2:0], 1'b1}
                                 : {w_div_sh[BITNESS-1:0], r_p[BITNESS-2:0], 1'b0};
    assign w_step     = r_is_div ? w_div_step : w_mul_step;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_is_div_nxt = r_is_div;
        w_b_nxt      = r_b;
        w_p_nxt      = r_p;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_ready_nxt  = 1'b0;
        w_carry_nxt  = r_carry;
        w_dz_nxt     = r_dz;
        w_bad_nxt    = r_bad;
        case (r_state)
            IDLE: begin
                if (io_bus.i_ready) begin
                    w_b_nxt   = io_bus.i_num_2;
                    w_p_nxt   = {{BITNESS{1'b0}}, io_bus.i_num_1};
                    w_cnt_nxt = '0;
                    case (io_bus.op_code)
                        ADD: begin
                            w_hi_nxt    = w_add[BITNESS-1:0];
                            w_lo_nxt    = '0;
                            w_carry_nxt = w_add[BITNESS];
                            w_dz_nxt    = 1'b0;
                            w_bad_nxt   = 1'b0;
                            w_ready_nxt = 1'b1;
                        end
                        SUB: begin
                            w_hi_nxt    = w_sub[BITNESS-1:0];
                            w_lo_nxt    = '0;
                            w_carry_nxt = w_sub[BITNESS];
                            w_dz_nxt    = 1'b0;
                            w_bad_nxt   = 1'b0;
                            w_ready_nxt = 1'b1;
                        end
                        MUL: begin
                            w_state_nxt  = RUN;
                            w_is_div_nxt = 1'b0;
                        end
                        DIV: begin
                            if (io_bus.i_num_2 == '0) begin
                                w_hi_nxt    = '1;
                                w_lo_nxt    = io_bus.i_num_1;
                                w_carry_nxt = 1'b0;
                                w_dz_nxt    = 1'b1;
                                w_bad_nxt   = 1'b0;
                                w_ready_nxt = 1'b1;
                            end else begin
                                w_state_nxt  = RUN;
                                w_is_div_nxt = 1'b1;
                            end
                        end
                        default: begin
                            w_hi_nxt    = '0;
                            w_lo_nxt    = '0;
                            w_carry_nxt = 1'b0;
                            w_dz_nxt    = 1'b0;
                            w_bad_nxt   = 1'b1;
                            w_ready_nxt = 1'b1;
                        end
                    endcase
                end
            end
            RUN: begin
                w_p_nxt   = w_step;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_hi_nxt    = r_is_div ? w_step[BITNESS-1:0] : w_step[2*BITNESS-1:BITNESS];
                    w_lo_nxt    = r_is_div ? w_step[2*BITNESS-1:BITNESS] : w_step[BITNESS-1:0];
                    w_carry_nxt = 1'b0;
                    w_dz_nxt    = 1'b0;
                    w_bad_nxt   = 1'b0;
                    w_ready_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_b      <= '0;
            r_p      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_ready  <= 1'b0;
            r_carry  <= 1'b0;
            r_dz     <= 1'b0;
            r_bad    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_is_div <= w_is_div_nxt;
            r_b      <= w_b_nxt;
            r_p      <= w_p_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_ready  <= w_ready_nxt;
            r_carry  <= w_carry_nxt;
            r_dz     <= w_dz_nxt;
            r_bad    <= w_bad_nxt;
        end
    end

    assign io_bus.o_busy     = (r_state == RUN);
    assign io_bus.o_ready    = r_ready;
    assign io_bus.result_Hi  = r_hi;
    assign io_bus.result_Lo  = r_lo;
    assign io_bus.o_carry    = r_carry;
    assign io_bus.o_div_zero = r_dz;
    assign io_bus.o_bad_op   = r_bad;
endmodule
